// File: rtl/lfsr_checker_if.sv
// Sample stream and status bundle between an LFSR source and its checker.
interface lfsr_checker_if #(
  parameter int unsigned ERR_W = 16
) ();

  logic [7:0]       DATA_IN;
  logic             DATA_VALID;
  logic             CLR_ERR;
  logic             LOCKED;
  logic             ERR_PULSE;
  logic [ERR_W-1:0] ERR_COUNT;
  logic [7:0]       EXPECTED;

  // Source side: drives samples and the clear request, observes status.
  modport master (
    output DATA_IN,
    output DATA_VALID,
    output CLR_ERR,
    input  LOCKED,
    input  ERR_PULSE,
    input  ERR_COUNT,
    input  EXPECTED
  );

  // Checker side.
  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    input  CLR_ERR,
    output LOCKED,
    output ERR_PULSE,
    output ERR_COUNT,
    output EXPECTED
  );

endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for an 8-bit LFSR stream. Seeds its predictor from incoming
// data, locks after a run of correct predictions, then counts errors while locked
// and flywheels through bad samples until too many consecutive misses drop lock.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input logic           CLK1,
  input logic           KEY0,
  lfsr_checker_if.slave bus
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  // One step of the source LFSR; taps feed fb into bits 0, 3, 4, 5 and 6.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic fb;
    fb = s[7];
    return {s[6], s[5] ^ fb, s[4] ^ fb, s[3] ^ fb, s[2] ^ fb, s[1], s[0], fb};
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [7:0]       expected_q,  expected_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q,  miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [7:0] din;
  logic       din_zero;
  logic       is_match;
  logic       err_hit;

  assign din      = bus.DATA_IN;
  assign din_zero = (din == 8'h00);
  assign is_match = (din == expected_q);

  // Acquisition / tracking state machine; everything advances only on valid samples.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_hit     = 1'b0;
    if (bus.DATA_VALID) begin
      case (state_q)
        StHunt: begin
          // Zero is the LFSR lockup value and cannot seed the predictor.
          if (!din_zero) begin
            expected_d  = lfsr_next(din);
            match_cnt_d = 4'd0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (is_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            expected_d  = lfsr_next(din);
            if (match_cnt_d == LockCnt) begin
              state_d    = StLocked;
              miss_cnt_d = 4'd0;
            end
          end else if (!din_zero) begin
            // Reseed from the new sample and start the run over.
            expected_d  = lfsr_next(din);
            match_cnt_d = 4'd0;
          end else begin
            state_d     = StHunt;
            expected_d  = 8'h00;
            match_cnt_d = 4'd0;
          end
        end
        StLocked: begin
          if (is_match) begin
            expected_d = lfsr_next(din);
            miss_cnt_d = 4'd0;
          end else begin
            err_hit    = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d == LossCnt) begin
              state_d     = StHunt;
              expected_d  = 8'h00;
              miss_cnt_d  = 4'd0;
              match_cnt_d = 4'd0;
            end else begin
              // Flywheel on our own prediction so bad data never shifts the phase.
              expected_d = lfsr_next(expected_q);
            end
          end
        end
        default: begin
          state_d     = StHunt;
          expected_d  = 8'h00;
          match_cnt_d = 4'd0;
          miss_cnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Error pulse and saturating counter; a clear coinciding with an error leaves one.
  always_comb begin
    err_pulse_d = err_hit;
    err_count_d = err_count_q;
    if (bus.CLR_ERR) begin
      err_count_d = err_hit ? ERR_W'(1) : '0;
    end else if (err_hit && !(&err_count_q)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK1 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= StHunt;
      expected_q  <= 8'h00;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.LOCKED    = (state_q == StLocked);
  assign bus.ERR_PULSE = err_pulse_q;
  assign bus.ERR_COUNT = err_count_q;
  assign bus.EXPECTED  = expected_q;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the 8-bit pseudo-random LFSR stream produced elsewhere in the design. One 8-bit sample arrives per qualified clock.
- Self-synchronises by seeding its own predictor from the incoming data, then declares lock after a run of correct predictions.
- While locked it flags and counts sample errors, and drops lock after repeated consecutive misses.
- Sits between the sequence source (or the link carrying it) and the status LEDs / 7-segment error display.

Parameters:
- LOCK_COUNT, 4, consecutive correct predictions in VERIFY needed to enter LOCKED (range 1..15)
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that force a return to HUNT (range 1..15)
- ERR_W, 16, width of the saturating error counter

Ports:
- CLK1  input  1  system clock; all state changes on its rising edge
- KEY0  input  1  reset, asynchronous, active-low
- DATA_IN  input  8  received LFSR sample
- DATA_VALID  input  1  DATA_IN is a new sample this cycle
- CLR_ERR  input  1  synchronous clear of ERR_COUNT
- LOCKED  output  1  high while in LOCKED state
- ERR_PULSE  output  1  one-cycle pulse per mismatched sample while LOCKED
- ERR_COUNT  output  ERR_W  saturating count of mismatches while LOCKED
- EXPECTED  output  8  current prediction of the next sample

Behaviour:
- Next-state function f(s), s = bits 7..0, fb = s[7]:
  - s0'=fb; s1'=s0; s2'=s1; s3'=s2^fb; s4'=s3^fb; s5'=s4^fb; s6'=s5^fb; s7'=s6
  - Reference sequence: FF->87->77->EE->A5. f(00)=00 (lockup), so 0x00 is never a valid seed.
- Reset (KEY0=0, asynchronous): state=HUNT, EXPECTED=0x00, match_cnt=0, miss_cnt=0, LOCKED=0, ERR_PULSE=0, ERR_COUNT=0.
  - Reset asserted mid-lock takes effect immediately.
- All decisions occur only on cycles with DATA_VALID=1. With DATA_VALID=0, all state holds and ERR_PULSE=0.
- Latency: the outputs for a sample sampled at edge k are registered and visible after edge k (1 cycle).
- HUNT:
  - DATA_IN!=0 -> EXPECTED=f(DATA_IN), match_cnt=0, go VERIFY.
  - DATA_IN==0 -> stay HUNT.
- VERIFY:
  - DATA_IN==EXPECTED -> match_cnt+1, EXPECTED=f(DATA_IN). If match_cnt reaches LOCK_COUNT -> LOCKED, miss_cnt=0.
  - Mismatch with DATA_IN!=0 -> reseed: EXPECTED=f(DATA_IN), match_cnt=0, stay VERIFY.
  - Mismatch with DATA_IN==0 -> HUNT.
- LOCKED:
  - Match -> EXPECTED=f(DATA_IN), miss_cnt=0.
  - Mismatch -> flywheel: EXPECTED=f(EXPECTED), never reseeded from bad data. Also ERR_PULSE=1, ERR_COUNT+1 (saturates at all-ones), miss_cnt+1.
  - miss_cnt reaching LOSS_COUNT -> HUNT, LOCKED=0, EXPECTED=0x00. The mismatch that causes loss is still counted and pulsed.
- ERR_PULSE and ERR_COUNT change only in LOCKED. VERIFY/HUNT mismatches are not errors.
- CLR_ERR:
  - Sets ERR_COUNT=0 on the next edge.
  - If CLR_ERR and a counted error occur in the same cycle, ERR_COUNT=1.
  - CLR_ERR does not affect state or lock.
- LOCKED is a decode of the registered state; no combinational path from inputs to outputs.

Test Plan:
- Lock acquisition: reset, then valid FF,87,77,EE,A5 on consecutive cycles -> LOCKED rises after the A5 edge. ERR_COUNT=0, EXPECTED=f(A5).
- Zero rejection: in HUNT, feed 00 ×3 then FF -> stays HUNT through the zeros, enters VERIFY on FF with EXPECTED=87, LOCKED=0 throughout.
- Single error while locked: lock as above, then inject a wrong value in place of f(A5), then the correct continuation -> one ERR_PULSE, ERR_COUNT=1, LOCKED stays 1, next correct sample matches (flywheel held phase).
- Loss of lock: while locked, feed 3 consecutive wrong samples -> ERR_PULSE on each, ERR_COUNT=3, LOCKED falls after the 3rd, EXPECTED=00. Re-feeding FF,87,77,EE,A5 relocks.
- Valid gaps and clear: locked stream with DATA_VALID low for 5 cycles between samples -> no change in state or EXPECTED. Then assert CLR_ERR in the same cycle as a mismatch with ERR_COUNT=7 -> ERR_COUNT=1.
- Async reset mid-lock plus saturation: assert KEY0 low between edges -> LOCKED, ERR_COUNT, EXPECTED go to 0 without waiting for a clock edge. Separately, with ERR_W=4, 20 locked errors (interleaved with matches to avoid loss) -> ERR_COUNT holds at 15.
